// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller and the MIPS datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         instr_op_i;
  logic               mem_ready_i;
  logic               pc_write_o;
  logic               pc_write_cond_o;
  logic               iord_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               ir_write_o;
  logic               reg_write_o;
  logic               reg_dst_o;
  logic               mem_to_reg_o;
  logic               alu_src_a_o;
  logic [1:0]         alu_src_b_o;
  logic [ALUOP_W-1:0] alu_op_o;
  logic [1:0]         pc_src_o;
  logic               instr_done_o;
  logic               trap_o;
  logic [1:0]         err_code_o;
  logic [3:0]         state_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o,
           ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o,
           alu_src_b_o, alu_op_o, pc_src_o, instr_done_o, trap_o,
           err_code_o, state_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o,
           ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o,
           alu_src_b_o, alu_op_o, pc_src_o, instr_done_o, trap_o,
           err_code_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/mem/writeback sequencing
// with memory-ready waits, illegal-opcode and memory-timeout traps.
module multicycle_ctrl #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_ctrl_if.master    bus
);
  // One spare bit of counter when the timeout is disabled keeps widths legal.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_CNT = CW'(MEM_TIMEOUT);

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;

  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_RD = 4'd4,
    MEM_WB = 4'd5, MEM_WR = 4'd6, EXEC_R = 4'd7, WB_R = 4'd8, EXEC_I = 4'd9,
    WB_I = 4'd10, BRANCH = 4'd11, JUMP = 4'd12, TRAP = 4'd15
  } state_t;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
    logic               done;
    logic               trap;
  } ctrl_t;

  state_t        r_state, w_nxt_state;
  logic [5:0]    r_op, w_nxt_op;
  logic [1:0]    r_err, w_nxt_err;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic          w_wait;
  ctrl_t         r_ctrl;

  // Moore output decode for a given state; registered against the next state.
  function automatic ctrl_t dec(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      DECODE:   c.alu_src_b = 2'b11;
      MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEM_RD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
      MEM_WR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_W'(2); end
      WB_R:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1; end
      EXEC_I:   begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.alu_op = (op == OP_ADDI) ? ALUOP_W'(3) : ALUOP_W'(4);
      end
      WB_I:     begin c.reg_write = 1'b1; c.done = 1'b1; end
      BRANCH:   begin
        c.alu_src_a = 1'b1; c.alu_op = ALUOP_W'(1);
        c.pc_write_cond = 1'b1; c.pc_src = 2'b01; c.done = 1'b1;
      end
      JUMP:     begin c.pc_write = 1'b1; c.pc_src = 2'b10; c.done = 1'b1; end
      TRAP:     c.trap = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next-state, opcode latch, error code and memory wait counter.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_op    = r_op;
    w_nxt_err   = r_err;
    w_nxt_cnt   = '0;
    w_wait      = 1'b0;
    case (r_state)
      IDLE:     w_nxt_state = FETCH;
      FETCH:    begin w_wait = 1'b1; if (bus.mem_ready_i) w_nxt_state = DECODE; end
      DECODE:   begin
        w_nxt_op = bus.instr_op_i;
        case (bus.instr_op_i)
          OP_R:           w_nxt_state = EXEC_R;
          OP_ADDI, OP_SLTI: w_nxt_state = EXEC_I;
          OP_LW, OP_SW:   w_nxt_state = MEM_ADDR;
          OP_BEQ:         w_nxt_state = BRANCH;
          OP_J:           w_nxt_state = JUMP;
          default:        begin w_nxt_state = TRAP; w_nxt_err = 2'b01; end
        endcase
      end
      MEM_ADDR: w_nxt_state = (r_op == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   begin w_wait = 1'b1; if (bus.mem_ready_i) w_nxt_state = MEM_WB; end
      MEM_WR:   begin w_wait = 1'b1; if (bus.mem_ready_i) w_nxt_state = FETCH; end
      EXEC_R:   w_nxt_state = WB_R;
      EXEC_I:   w_nxt_state = WB_I;
      MEM_WB, WB_R, WB_I, BRANCH, JUMP: w_nxt_state = FETCH;
      TRAP:     w_nxt_state = TRAP;
      default:  begin w_nxt_state = TRAP; w_nxt_err = 2'b01; end
    endcase
    // Ready in the final allowed cycle still completes the access.
    if (w_wait && !bus.mem_ready_i && (MEM_TIMEOUT > 0)) begin
      if (r_cnt == TO_CNT) begin
        w_nxt_state = TRAP;
        w_nxt_err   = 2'b10;
      end else begin
        w_nxt_cnt = r_cnt + 1'b1;
      end
    end
  end

  // State register and registered Moore outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_op    <= w_nxt_op;
      r_err   <= w_nxt_err;
      r_cnt   <= w_nxt_cnt;
      r_ctrl  <= dec(w_nxt_state, w_nxt_op);
    end
  end

  // FETCH strobes and MEM_WR retire follow the ready handshake combinationally.
  assign bus.pc_write_o      = r_ctrl.pc_write | ((r_state == FETCH) & bus.mem_ready_i);
  assign bus.ir_write_o      = (r_state == FETCH) & bus.mem_ready_i;
  assign bus.instr_done_o    = r_ctrl.done | ((r_state == MEM_WR) & bus.mem_ready_i);
  assign bus.pc_write_cond_o = r_ctrl.pc_write_cond;
  assign bus.iord_o          = r_ctrl.iord;
  assign bus.mem_read_o      = r_ctrl.mem_read;
  assign bus.mem_write_o     = r_ctrl.mem_write;
  assign bus.reg_write_o     = r_ctrl.reg_write;
  assign bus.reg_dst_o       = r_ctrl.reg_dst;
  assign bus.mem_to_reg_o    = r_ctrl.mem_to_reg;
  assign bus.alu_src_a_o     = r_ctrl.alu_src_a;
  assign bus.alu_src_b_o     = r_ctrl.alu_src_b;
  assign bus.alu_op_o        = r_ctrl.alu_op;
  assign bus.pc_src_o        = r_ctrl.pc_src;
  assign bus.trap_o          = r_ctrl.trap;
  assign bus.err_code_o      = r_err;
  assign bus.state_o         = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (MEM_TIMEOUT = 4).
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  multicycle_ctrl_if #(.ALUOP_W(3)) bus();

  multicycle_ctrl #(.ALUOP_W(3), .MEM_TIMEOUT(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [20:0] ctl;
  assign ctl = {bus.pc_write_o, bus.pc_write_cond_o, bus.iord_o, bus.mem_read_o,
                bus.mem_write_o, bus.ir_write_o, bus.reg_write_o, bus.reg_dst_o,
                bus.mem_to_reg_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o,
                bus.pc_src_o, bus.instr_done_o, bus.trap_o, bus.err_code_o};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.instr_op_i  = 6'b000000;
    bus.mem_ready_i = 1'b0;
    rst = 1'b0;
    step(); step();
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_outputs", 32'(ctl), 0);

    // R-type, ready tied high
    rst = 1'b1; bus.mem_ready_i = 1'b1; bus.instr_op_i = 6'b000000;
    step();
    chk("r_fetch_state", 32'(bus.state_o), 1);
    chk("r_fetch_irw", 32'({bus.ir_write_o, bus.pc_write_o, bus.mem_read_o, bus.iord_o}), 4'b1110);
    chk("r_fetch_srcb", 32'(bus.alu_src_b_o), 1);
    step();
    chk("r_decode_state", 32'(bus.state_o), 2);
    chk("r_decode_srcb", 32'(bus.alu_src_b_o), 3);
    step();
    chk("r_exec_state", 32'(bus.state_o), 7);
    chk("r_exec_aluop", 32'({bus.alu_op_o, bus.alu_src_a_o, bus.alu_src_b_o}), 6'b010_1_00);
    chk("r_exec_done", 32'(bus.instr_done_o), 0);
    step();
    chk("r_wb_state", 32'(bus.state_o), 8);
    chk("r_wb_ctl", 32'({bus.reg_write_o, bus.reg_dst_o, bus.instr_done_o}), 3'b111);
    step();
    chk("r_back_fetch", 32'(bus.state_o), 1);
    chk("r_done_once", 32'(bus.instr_done_o), 0);

    // lw with 3 wait cycles in MEM_RD
    bus.instr_op_i = 6'b100011;
    step();
    chk("lw_decode", 32'(bus.state_o), 2);
    bus.mem_ready_i = 1'b0;
    step();
    chk("lw_memaddr", 32'(bus.state_o), 3);
    chk("lw_memaddr_src", 32'({bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o}), 6'b1_10_000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lw_memrd_hold", 32'({bus.state_o, bus.mem_read_o, bus.iord_o}), {4'd4, 2'b11});
    end
    bus.mem_ready_i = 1'b1;
    step();
    chk("lw_memwb_state", 32'(bus.state_o), 5);
    chk("lw_memwb_ctl", 32'({bus.reg_write_o, bus.mem_to_reg_o, bus.reg_dst_o, bus.instr_done_o}), 4'b1101);
    step();
    chk("lw_back_fetch", 32'(bus.state_o), 1);

    // addi then slti
    bus.instr_op_i = 6'b001000;
    step(); step();
    chk("addi_exec", 32'({bus.state_o, bus.alu_op_o, bus.alu_src_b_o}), {4'd9, 3'b011, 2'b10});
    step();
    chk("addi_wb", 32'({bus.state_o, bus.reg_write_o, bus.reg_dst_o, bus.instr_done_o}), {4'd10, 3'b101});
    bus.instr_op_i = 6'b001010;
    step(); step(); step();
    chk("slti_exec", 32'({bus.state_o, bus.alu_op_o}), {4'd9, 3'b100});
    step();
    chk("slti_wb", 32'({bus.state_o, bus.reg_dst_o}), {4'd10, 1'b0});

    // beq then j
    bus.instr_op_i = 6'b000100;
    step(); step(); step();
    chk("beq_branch", 32'({bus.state_o, bus.pc_write_cond_o, bus.alu_op_o, bus.pc_src_o, bus.instr_done_o, bus.pc_write_o}),
        {4'd11, 1'b1, 3'b001, 2'b01, 1'b1, 1'b0});
    bus.instr_op_i = 6'b000010;
    step(); step(); step();
    chk("j_jump", 32'({bus.state_o, bus.pc_write_o, bus.pc_src_o, bus.instr_done_o}), {4'd12, 1'b1, 2'b10, 1'b1});

    // sw: done follows ready combinationally in MEM_WR
    bus.instr_op_i = 6'b101011;
    step(); step(); step();
    bus.mem_ready_i = 1'b0;
    step();
    chk("sw_memwr", 32'({bus.state_o, bus.mem_write_o, bus.iord_o, bus.instr_done_o}), {4'd6, 3'b110});
    bus.mem_ready_i = 1'b1;
    #1;
    chk("sw_done_ready", 32'(bus.instr_done_o), 1);
    step();
    chk("sw_back_fetch", 32'(bus.state_o), 1);

    // illegal opcode -> sticky TRAP until reset
    bus.instr_op_i = 6'b111111;
    step(); step();
    chk("ill_trap", 32'({bus.state_o, bus.trap_o, bus.err_code_o, bus.pc_write_o, bus.mem_read_o}), {4'd15, 1'b1, 2'b01, 2'b00});
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ill_trap_hold", 32'({bus.state_o, bus.err_code_o}), {4'd15, 2'b01});
    end
    rst = 1'b0;
    step();
    chk("ill_rst_idle", 32'(bus.state_o), 0);
    chk("ill_rst_outputs", 32'(ctl), 0);
    rst = 1'b1; bus.mem_ready_i = 1'b0;
    step();
    chk("to_fetch", 32'(bus.state_o), 1);

    // timeout: 5 wait cycles in FETCH, then TRAP err 10
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_fetch_wait", 32'({bus.state_o, bus.ir_write_o}), {4'd1, 1'b0});
    end
    step();
    chk("to_trap", 32'({bus.state_o, bus.trap_o, bus.err_code_o}), {4'd15, 1'b1, 2'b10});

    // same, with ready arriving on the 5th wait cycle
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("to2_fetch", 32'(bus.state_o), 1);
    for (int i = 0; i < 4; i++) step();
    chk("to2_still_fetch", 32'(bus.state_o), 1);
    bus.mem_ready_i = 1'b1;
    #1;
    chk("to2_irw", 32'(bus.ir_write_o), 1);
    step();
    chk("to2_decode", 32'({bus.state_o, bus.trap_o, bus.err_code_o}), {4'd2, 3'b000});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the MIPS datapath. It replaces the single-cycle opcode decoder with a registered state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It waits on a memory ready handshake and traps on illegal opcodes or memory timeouts. It sits between the instruction register's opcode field and every datapath mux and write enable.

## Interface
- ALUOP_W, 3, width of alu_op_o; must be >= 3.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready_i in a memory state; 0 disables the timeout.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- instr_op_i  in  6  opcode, IR[31:26]; valid from DECODE onward.
- mem_ready_i  in  1  memory done for the current access.
- pc_write_o, pc_write_cond_o  out  1  unconditional / branch-conditional PC write.
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o, mem_write_o, ir_write_o  out  1  memory and IR strobes.
- reg_write_o, reg_dst_o, mem_to_reg_o  out  1  register-file controls (reg_dst 1 = rd).
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b_o  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-ext imm, 11 = imm<<2.
- alu_op_o  out  ALUOP_W  ALU operation, zero-extended: 000 add, 001 sub, 010 funct, 011 addi, 100 slti.
- pc_src_o  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- instr_done_o  out  1  one-cycle pulse when an instruction retires.
- trap_o  out  1  sticky; high while in TRAP.
- err_code_o  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- state_o  out  4  current state encoding.

## Operation
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, WB_R 8, EXEC_I 9, WB_I 10, BRANCH 11, JUMP 12, TRAP 15. Encodings 13 and 14 are unused and go to TRAP with err 01.
- Reset (rst_i = 0 at an edge) forces state IDLE, clears wait_cnt, op_q and err_code_o.
  - Reset takes effect from any state, including mid-wait and TRAP.
- IDLE: all outputs 0; goes to FETCH next cycle.
- FETCH drives mem_read=1, iord=0, src_a=0, src_b=01, alu_op=000, pc_src=00.
  - ir_write and pc_write are asserted only while mem_ready_i = 1, combinationally gated.
  - Moves to DECODE on ready; otherwise stays.
- DECODE drives src_a=0, src_b=11, alu_op=000, and latches instr_op_i into op_q. Next state by opcode:
  - 000000 -> EXEC_R
  - 001000 or 001010 -> EXEC_I
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> TRAP with err 01
- MEM_ADDR drives src_a=1, src_b=10, alu_op=000; goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD drives mem_read=1, iord=1; moves to MEM_WB on ready.
- MEM_WB drives reg_write=1, mem_to_reg=1, reg_dst=0, done; goes to FETCH.
- MEM_WR drives mem_write=1, iord=1; on ready pulses done and goes to FETCH.
- EXEC_R drives src_a=1, src_b=00, alu_op=010; goes to WB_R.
- WB_R drives reg_write=1, reg_dst=1, done; goes to FETCH.
- EXEC_I drives src_a=1, src_b=10; alu_op is 011 for addi (op_q 001000) and 100 for slti; goes to WB_I.
- WB_I drives reg_write=1, reg_dst=0, done; goes to FETCH.
- BRANCH drives src_a=1, src_b=00, alu_op=001, pc_write_cond=1, pc_src=01, done; goes to FETCH.
- JUMP drives pc_write=1, pc_src=10, done; goes to FETCH.
- TRAP: all strobes 0, trap_o=1, err_code held; exits only via reset.
- Memory timeout, only when MEM_TIMEOUT > 0:
  - wait_cnt (clog2(MEM_TIMEOUT+1) bits) increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready_i = 0.
  - wait_cnt clears on ready and on every state change.
  - When wait_cnt == MEM_TIMEOUT and ready is still 0, the next state is TRAP with err 10.
  - If ready arrives in that same cycle, ready wins and the access completes.
- Any output not listed for a state is 0.

## Timing
- Control outputs are Moore (decoded from registered state), except:
  - FETCH ir_write and pc_write, which follow mem_ready_i in the same cycle;
  - MEM_WR instr_done_o, which follows mem_ready_i in the same cycle.
- Latency, fetch to retire, with ready at first request:
  - lw 5 cycles;
  - R, addi, slti, sw 4 cycles;
  - beq, j 3 cycles.
- Each memory wait cycle adds 1 cycle.
- First FETCH is 1 cycle after reset release.
- All outputs are 0 during reset and in IDLE.

## Test plan
- Reset, then R-type with ready tied 1 -> states 1, 2, 7, 8, 1. In WB_R: reg_write=1, reg_dst=1. Done pulses once.
- lw, with ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles; MEM_WB has mem_to_reg=1. Retire at cycle 8.
- addi then slti -> EXEC_I alu_op is 011, then 100; in WB_I reg_dst=0.
- beq, then j -> BRANCH has pc_write_cond=1, alu_op=001, pc_src=01; JUMP has pc_write=1, pc_src=10.
- Opcode 111111 in DECODE -> TRAP, trap_o=1, err 01; stays there 20 cycles until rst_i is pulsed low, then IDLE.
- MEM_TIMEOUT=4, ready held 0 in FETCH -> TRAP with err 10 after 5 wait cycles.
  - Repeat with ready asserted on that 5th cycle -> goes to DECODE, no trap.
